y86_imem_writer: RTL and testbench

Serialises decoded Y86-64 instruction fields (icode, ifun, rA, rB, valC) into the Y86-64 byte encoding. Writes those bytes one per cycle into the byte-wide instruction memory that the fetch stage reads. It is the writer end of the fetch interface, used for program loading and for self-checking benches: encode, then fetch, and the fields must round-trip. Each instruction is placed at a running write pointer, which advances by the instruction length (valP semantics).

---
 rtl/y86_pkg.sv | 37 +++
 rtl/y86_imem_writer_if.sv | 22 ++
 rtl/y86_instr_len.sv | 47 ++++
 rtl/y86_imem_writer.sv | 153 +++++++++++++++
 tb/tb_y86_imem_writer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the instruction-memory writer and the fetch
// stage: instruction codes, the "no register" id, instruction lengths and
// the writer FSM state type.
package y86_pkg;

  // Instruction codes (high nibble of the opcode byte).
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Register id meaning "no register".
  localparam logic [3:0] RNONE = 4'hF;

  // Instruction lengths in bytes.
  localparam logic [3:0] LEN_1  = 4'd1;
  localparam logic [3:0] LEN_2  = 4'd2;
  localparam logic [3:0] LEN_9  = 4'd9;
  localparam logic [3:0] LEN_10 = 4'd10;

  // Writer FSM: IDLE accepts, then one state per encoded field.
  typedef enum logic [1:0] {
    S_IDLE,
    S_OPC,
    S_REG,
    S_CONST
  } wr_state_e;

endpackage

// File: rtl/y86_imem_writer_if.sv
// Decoded-instruction handshake between an instruction producer (master)
// and the memory writer (slave). A transfer happens on a rising clock edge
// where instr_valid & instr_ready.
//   instr_valid : fields below are valid
//   instr_ready : writer accepts the fields this cycle
//   icode/ifun  : instruction and function code
//   rA/rB       : register ids (4'hF = none)
//   valC        : 64-bit constant or destination
interface y86_imem_writer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;

  modport master (output instr_valid, icode, ifun, rA, rB, valC,
                  input  instr_ready);
  modport slave  (input  instr_valid, icode, ifun, rA, rB, valC,
                  output instr_ready);
endinterface

// File: rtl/y86_instr_len.sv
// Combinational instruction-shape decoder, shared with the fetch stage so
// encoder and decoder agree on every length.
//   icode_i       : instruction code
//   valid_o       : icode is a defined instruction
//   need_regids_o : instruction carries a register-id byte
//   need_valC_o   : instruction carries an 8-byte constant
//   len_o         : total length in bytes (0 when invalid)
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic       valid_o,
  output logic       need_regids_o,
  output logic       need_valC_o,
  output logic [3:0] len_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    valid_o       = 1'b1;
    need_regids_o = 1'b0;
    need_valC_o   = 1'b0;
    len_o         = LEN_1;
    case (icode_i)
      I_HALT, I_NOP, I_RET: ;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
        need_regids_o = 1'b1;
        len_o         = LEN_2;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        need_regids_o = 1'b1;
        need_valC_o   = 1'b1;
        len_o         = LEN_10;
      end
      I_JXX, I_CALL: begin
        need_valC_o = 1'b1;
        len_o       = LEN_9;
      end
      default: begin
        valid_o = 1'b0;
        len_o   = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/y86_imem_writer.sv
// Y86-64 instruction encoder: accepts decoded fields and writes the byte
// encoding, one byte per cycle, into the byte-wide instruction memory at a
// running write pointer (valP semantics).
//   clk_i, rst_n_i  : clock, synchronous active-low reset
//   start_load_i    : in IDLE, load pointer from start_addr_i, clear error
//   start_addr_i    : new write-pointer value
//   instr_if        : decoded-instruction handshake (slave side)
//   wr_en_o/wr_addr_o/wr_data_o : memory byte-write port
//   next_pc_o       : current write pointer
//   busy_o          : FSM not idle
//   instr_invalid_o : one-cycle pulse after an undefined icode is consumed
//   mem_error_o     : sticky, instruction would have crossed MEM_BYTES
module y86_imem_writer
  import y86_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_load_i,
  input  logic [63:0]       start_addr_i,
  y86_imem_writer_if.slave  instr_if,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic [63:0]       next_pc_o,
  output logic              busy_o,
  output logic              instr_invalid_o,
  output logic              mem_error_o
);

  wr_state_e   state_q, state_d;
  logic [63:0] ptr_q;
  logic [2:0]  idx_q;
  logic        mem_error_q;
  logic        invalid_q;

  // Fields captured at acceptance.
  logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
  logic [63:0] valc_q;
  logic        need_regids_q, need_valc_q;

  logic        len_valid, need_regids, need_valc;
  logic [3:0]  len;
  logic        accept;
  logic        out_of_bounds;
  logic [64:0] end_addr;

  y86_instr_len u_len (
    .icode_i       (instr_if.icode),
    .valid_o       (len_valid),
    .need_regids_o (need_regids),
    .need_valC_o   (need_valc),
    .len_o         (len)
  );

  // start_load_i wins over a pending instruction in the same cycle.
  assign instr_if.instr_ready = (state_q == S_IDLE) & ~start_load_i &
                                ~mem_error_q & rst_n_i;
  assign accept = instr_if.instr_valid & instr_if.instr_ready;

  // One extra bit so a pointer near 2^64 cannot wrap past the bound.
  assign end_addr      = {1'b0, ptr_q} + 65'(len);
  assign out_of_bounds = end_addr > 65'(MEM_BYTES);

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && len_valid && !out_of_bounds) state_d = S_OPC;
      S_OPC:   state_d = need_regids_q ? S_REG :
                         (need_valc_q ? S_CONST : S_IDLE);
      S_REG:   state_d = need_valc_q ? S_CONST : S_IDLE;
      S_CONST: if (idx_q == 3'd7) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs, decoded from registered state only.
  always_comb begin
    wr_en_o   = 1'b0;
    wr_data_o = 8'h00;
    case (state_q)
      S_OPC: begin
        wr_en_o   = 1'b1;
        wr_data_o = {icode_q, ifun_q};
      end
      S_REG: begin
        wr_en_o   = 1'b1;
        wr_data_o = {ra_q, rb_q};
      end
      S_CONST: begin
        wr_en_o   = 1'b1;
        wr_data_o = valc_q[{idx_q, 3'b000} +: 8];  // little-endian
      end
      default: ;
    endcase
  end

  assign wr_addr_o       = ptr_q[ADDR_W-1:0];
  assign next_pc_o       = ptr_q;
  assign busy_o          = (state_q != S_IDLE);
  assign instr_invalid_o = invalid_q;
  assign mem_error_o     = mem_error_q;

  // NOTE: captured fields are not reset; they are only read in states that
  // can be reached after an acceptance has loaded them.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      icode_q       <= instr_if.icode;
      ifun_q        <= instr_if.ifun;
      ra_q          <= instr_if.rA;
      rb_q          <= instr_if.rB;
      valc_q        <= instr_if.valC;
      need_regids_q <= need_regids;
      need_valc_q   <= need_valc;
    end
  end

  // Pointer, byte index and status flags.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ptr_q       <= 64'd0;
      idx_q       <= 3'd0;
      mem_error_q <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      invalid_q <= 1'b0;
      idx_q     <= (state_q == S_CONST) ? idx_q + 3'd1 : 3'd0;
      if (state_q == S_IDLE) begin
        if (start_load_i) begin
          ptr_q       <= start_addr_i;
          mem_error_q <= 1'b0;
        end else if (accept) begin
          if (!len_valid)        invalid_q   <= 1'b1;
          else if (out_of_bounds) mem_error_q <= 1'b1;
        end
      end else begin
        ptr_q <= ptr_q + 64'd1;  // one byte written this cycle
      end
    end
  end

endmodule

// File: tb/tb_y86_imem_writer.sv
// Directed bench for y86_imem_writer. Expected writes are queued by the
// stimulus; a negedge monitor pops and compares each DUT write.
module tb_y86_imem_writer;
  import y86_pkg::*;

  localparam int ADDR_W    = 10;
  localparam int MEM_BYTES = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_load = 1'b0;
  logic [63:0]       start_addr = 64'd0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [63:0]       next_pc;
  logic              busy, instr_invalid, mem_error;

  y86_imem_writer_if bus ();

  y86_imem_writer #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .start_load_i    (start_load),
    .start_addr_i    (start_addr),
    .instr_if        (bus),
    .wr_en_o         (wr_en),
    .wr_addr_o       (wr_addr),
    .wr_data_o       (wr_data),
    .next_pc_o       (next_pc),
    .busy_o          (busy),
    .instr_invalid_o (instr_invalid),
    .mem_error_o     (mem_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] mem [MEM_BYTES];
  int         n_vec = 0;
  int         n_err = 0;
  int         wr_count = 0;
  int         base;

  logic [7:0] irm_bytes [10] = '{8'h30, 8'hF5, 8'h88, 8'h77, 8'h66,
                                 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0] jmp_bytes [9]  = '{8'h70, 8'h00, 8'h10, 8'h00, 8'h00,
                                 8'h00, 8'h00, 8'h00, 8'h00};

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out, required completion within 50 cycles", name);
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_count++;
      mem[wr_addr] = wr_data;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %02h, required none",
                 wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("write@%0d", mon_e.addr),
              64'({wr_addr, wr_data}), 64'(mon_e));
      end
    end
  end

  // Bench-side length table used to decode the written bytes.
  function automatic int tb_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:             return 1;
      4'h2, 4'h6, 4'hA, 4'hB:       return 2;
      4'h3, 4'h4, 4'h5:             return 10;
      4'h7, 4'h8:                   return 9;
      default:                      return 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input int a, input logic [7:0] d);
    wr_t e;
    e.addr = a[ADDR_W-1:0];
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [63:0] a);
    start_load = 1'b1;
    start_addr = a;
    @(negedge clk);
    check("ready_during_load", 64'(bus.instr_ready), 64'd0);
    tick();
    start_load = 1'b0;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] c);
    bus.icode = ic;
    bus.ifun  = fn;
    bus.rA    = ra;
    bus.rB    = rb;
    bus.valC  = c;
    bus.instr_valid = 1'b1;
  endtask

  // Returns just after the accepting edge.
  task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [3:0] ra, input logic [3:0] rb,
                      input logic [63:0] c);
    int n = 0;
    drive(ic, fn, ra, rb, c);
    @(negedge clk);
    while (!bus.instr_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) timeout("send_accept");
    tick();
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) timeout("wait_idle");
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.icode = 4'h0;
    bus.ifun  = 4'h0;
    bus.rA    = RNONE;
    bus.rB    = RNONE;
    bus.valC  = 64'd0;

    // 1. Reset, then nop and halt.
    repeat (2) tick();
    check("rst_wr_en",   64'(wr_en), 64'd0);
    check("rst_next_pc", next_pc, 64'd0);
    check("rst_busy",    64'(busy), 64'd0);
    check("rst_invalid", 64'(instr_invalid), 64'd0);
    check("rst_memerr",  64'(mem_error), 64'd0);
    check("rst_ready",   64'(bus.instr_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(bus.instr_ready), 64'd1);
    tick();

    load(64'd0);
    base = wr_count;
    expect_wr(0, 8'h10);
    send(I_NOP, 4'h0, RNONE, RNONE, 64'd0);
    wait_idle();
    check("nop_writes", 64'(wr_count - base), 64'd1);
    base = wr_count;
    expect_wr(1, 8'h00);
    send(I_HALT, 4'h0, RNONE, RNONE, 64'd0);
    wait_idle();
    check("halt_writes", 64'(wr_count - base), 64'd1);
    check("pc_after_halt", next_pc, 64'd2);

    // 2. irmovq at 10, then decode it back.
    load(64'd10);
    base = wr_count;
    for (int i = 0; i < 10; i++) expect_wr(10 + i, irm_bytes[i]);
    send(I_IRMOVQ, 4'h0, RNONE, 4'h5, 64'h1122334455667788);
    wait_idle();
    check("irmovq_writes", 64'(wr_count - base), 64'd10);
    check("pc_after_irmovq", next_pc, 64'd20);
    begin
      logic [63:0] v;
      v = 64'd0;
      for (int k = 7; k >= 0; k--) v = {v[55:0], mem[12 + k]};
      check("fetch_valP", 64'(10 + tb_len(mem[10][7:4])), 64'd20);
      check("fetch_rA",   64'(mem[11][7:4]), 64'hF);
      check("fetch_rB",   64'(mem[11][3:0]), 64'h5);
      check("fetch_valC", v, 64'h1122334455667788);
    end

    // 3. jmp continues at 20, no register byte.
    base = wr_count;
    for (int i = 0; i < 9; i++) expect_wr(20 + i, jmp_bytes[i]);
    send(I_JXX, 4'h0, RNONE, RNONE, 64'h1000);
    wait_idle();
    check("jmp_writes", 64'(wr_count - base), 64'd9);
    check("pc_after_jmp", next_pc, 64'd29);

    // 4. Invalid icode.
    base = wr_count;
    send(4'hC, 4'h0, RNONE, RNONE, 64'd0);
    @(negedge clk);
    check("invalid_pulse", 64'(instr_invalid), 64'd1);
    check("invalid_busy",  64'(busy), 64'd0);
    @(negedge clk);
    check("invalid_one_cycle", 64'(instr_invalid), 64'd0);
    tick();
    check("invalid_writes", 64'(wr_count - base), 64'd0);
    check("invalid_pc", next_pc, 64'd29);
    expect_wr(29, 8'h10);
    send(I_NOP, 4'h0, RNONE, RNONE, 64'd0);
    wait_idle();
    check("pc_after_invalid_nop", next_pc, 64'd30);

    // 5. Exact fit at the top of memory, then overflow.
    load(64'd1014);
    base = wr_count;
    for (int i = 0; i < 10; i++) expect_wr(1014 + i, irm_bytes[i]);
    send(I_IRMOVQ, 4'h0, RNONE, 4'h5, 64'h1122334455667788);
    wait_idle();
    check("fit_writes", 64'(wr_count - base), 64'd10);
    check("fit_pc", next_pc, 64'd1024);
    check("fit_memerr", 64'(mem_error), 64'd0);

    load(64'd1020);
    base = wr_count;
    send(I_IRMOVQ, 4'h0, RNONE, 4'h5, 64'h1122334455667788);
    @(negedge clk);
    check("oob_memerr", 64'(mem_error), 64'd1);
    check("oob_busy",   64'(busy), 64'd0);
    drive(I_NOP, 4'h0, RNONE, RNONE, 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("oob_ready", 64'(bus.instr_ready), 64'd0);
    end
    tick();
    bus.instr_valid = 1'b0;
    check("oob_writes", 64'(wr_count - base), 64'd0);
    check("oob_pc", next_pc, 64'd1020);
    load(64'd0);
    @(negedge clk);
    check("clear_memerr", 64'(mem_error), 64'd0);
    check("clear_ready",  64'(bus.instr_ready), 64'd1);
    check("clear_pc",     next_pc, 64'd0);
    tick();

    // 6a. start_load and instr_valid together: load wins, accept next cycle.
    start_load = 1'b1;
    start_addr = 64'd40;
    drive(I_NOP, 4'h0, RNONE, RNONE, 64'd0);
    @(negedge clk);
    check("both_ready", 64'(bus.instr_ready), 64'd0);
    tick();
    start_load = 1'b0;
    check("both_not_accepted", 64'(busy), 64'd0);
    check("both_pc", next_pc, 64'd40);
    expect_wr(40, 8'h10);
    @(negedge clk);
    check("both_ready_next", 64'(bus.instr_ready), 64'd1);
    tick();
    bus.instr_valid = 1'b0;
    check("both_accepted", 64'(busy), 64'd1);
    wait_idle();
    check("both_pc_after", next_pc, 64'd41);

    // 6b. Reset during the third write of an irmovq.
    load(64'd0);
    base = wr_count;
    expect_wr(0, 8'h30);
    expect_wr(1, 8'hF5);
    expect_wr(2, 8'h88);
    send(I_IRMOVQ, 4'h0, RNONE, 4'h5, 64'h1122334455667788);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_wr_en", 64'(wr_en), 64'd0);
    check("midrst_pc",    next_pc, 64'd0);
    check("midrst_busy",  64'(busy), 64'd0);
    check("midrst_writes", 64'(wr_count - base), 64'd3);
    rst_n = 1'b1;
    expect_wr(0, 8'h10);
    send(I_NOP, 4'h0, RNONE, RNONE, 64'd0);
    wait_idle();
    check("post_rst_pc", next_pc, 64'd1);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
